// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and FU-issue signals of the ALU issue queue.
// master drives dispatch/wakeup/fu_is_available; slave is the queue itself.
interface issue_queue_if;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [3:0]  dispatch_ALUControl;
    logic        dispatch_ALUSrc;
    logic [31:0] dispatch_imm;
    logic        dispatch_rs1_ready;
    logic        dispatch_rs2_ready;
    logic [5:0]  dispatch_rs1_tag;
    logic [5:0]  dispatch_rs2_tag;
    logic [31:0] dispatch_rs1_value;
    logic [31:0] dispatch_rs2_value;
    logic [5:0]  dispatch_tag_to_output;
    logic [5:0]  dispatch_rob_index;
    logic        wakeup_active;
    logic [5:0]  wakeup_tag;
    logic [31:0] wakeup_value;
    logic        fu_is_available;
    logic        write_enable;
    logic [3:0]  ALUControl;
    logic        ALUSrc;
    logic [31:0] imm;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [5:0]  tag_to_output;
    logic [5:0]  rob_index;
    logic [4:0]  occupancy;

    modport master (
        output dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc, dispatch_imm,
               dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_tag, dispatch_rs2_tag,
               dispatch_rs1_value, dispatch_rs2_value, dispatch_tag_to_output,
               dispatch_rob_index, wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
        input  dispatch_ready, write_enable, ALUControl, ALUSrc, imm, rs1_value,
               rs2_value, tag_to_output, rob_index, occupancy
    );

    modport slave (
        input  dispatch_valid, dispatch_ALUControl, dispatch_ALUSrc, dispatch_imm,
               dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_tag, dispatch_rs2_tag,
               dispatch_rs1_value, dispatch_rs2_value, dispatch_tag_to_output,
               dispatch_rob_index, wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
        output dispatch_ready, write_enable, ALUControl, ALUSrc, imm, rs1_value,
               rs2_value, tag_to_output, rob_index, occupancy
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing reservation-station issue queue for one ALU, oldest-ready-first.
// Optional ISSUE_WAKEUP_BYPASS_EN: entries woken this cycle may issue this cycle.
module issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    issue_queue_if.slave io
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [3:0]  op;
        logic        alu_src;
        logic [31:0] imm;
        logic        r1_rdy;
        logic [5:0]  r1_tag;
        logic [31:0] r1_val;
        logic        r2_rdy;
        logic [5:0]  r2_tag;
        logic [31:0] r2_val;
        logic [5:0]  dest;
        logic [5:0]  rob;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    entry_t           woken   [DEPTH];
    entry_t           incoming;
    entry_t           pick;
    logic [4:0]       count_q, count_d, count_rm;
    logic [DEPTH-1:0] elig;
    logic [IW-1:0]    sel;
    logic             found, issue, accept, ready_out;

    always_comb begin
        // Every stored entry as it looks after this cycle's wakeup snoop.
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entry_q[i];
            if (io.wakeup_active && !entry_q[i].r1_rdy && entry_q[i].r1_tag == io.wakeup_tag) begin
                woken[i].r1_rdy = 1'b1;
                woken[i].r1_val = io.wakeup_value;
            end
            if (io.wakeup_active && !entry_q[i].r2_rdy && entry_q[i].r2_tag == io.wakeup_tag) begin
                woken[i].r2_rdy = 1'b1;
                woken[i].r2_val = io.wakeup_value;
            end
`ifdef ISSUE_WAKEUP_BYPASS_EN
            elig[i] = (5'(i) < count_q) && woken[i].r1_rdy && woken[i].r2_rdy;
`else
            elig[i] = (5'(i) < count_q) && entry_q[i].r1_rdy && entry_q[i].r2_rdy;
`endif
        end

        sel   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
        issue     = io.fu_is_available && found && !reset;
        ready_out = !reset && (count_q < 5'(DEPTH));
        accept    = io.dispatch_valid && ready_out;

`ifdef ISSUE_WAKEUP_BYPASS_EN
        pick = woken[sel];
`else
        pick = entry_q[sel];
`endif

        incoming.op      = io.dispatch_ALUControl;
        incoming.alu_src = io.dispatch_ALUSrc;
        incoming.imm     = io.dispatch_imm;
        incoming.r1_tag  = io.dispatch_rs1_tag;
        incoming.r2_tag  = io.dispatch_rs2_tag;
        incoming.dest    = io.dispatch_tag_to_output;
        incoming.rob     = io.dispatch_rob_index;
        incoming.r1_rdy  = io.dispatch_rs1_ready;
        incoming.r1_val  = io.dispatch_rs1_value;
        incoming.r2_rdy  = io.dispatch_rs2_ready || io.dispatch_ALUSrc;
        incoming.r2_val  = io.dispatch_rs2_value;
        // Same-cycle wakeup must be captured at dispatch or it is lost for good.
        if (!incoming.r1_rdy && io.wakeup_active && io.dispatch_rs1_tag == io.wakeup_tag) begin
            incoming.r1_rdy = 1'b1;
            incoming.r1_val = io.wakeup_value;
        end
        if (!incoming.r2_rdy && io.wakeup_active && io.dispatch_rs2_tag == io.wakeup_tag) begin
            incoming.r2_rdy = 1'b1;
            incoming.r2_val = io.wakeup_value;
        end

        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = woken[i];
            if (issue && (IW'(i) >= sel) && (i < DEPTH - 1))
                entry_d[i] = woken[i + 1];
        end
        count_rm = count_q - {4'b0, issue};
        if (accept)
            entry_d[count_rm[IW-1:0]] = incoming;
        count_d = count_rm + {4'b0, accept};
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
        entry_q <= entry_d;
    end

    assign io.dispatch_ready = ready_out;
    assign io.write_enable   = issue;
    assign io.ALUControl     = pick.op;
    assign io.ALUSrc         = pick.alu_src;
    assign io.imm            = pick.imm;
    assign io.rs1_value      = pick.r1_val;
    assign io.rs2_value      = pick.r2_val;
    assign io.tag_to_output  = pick.dest;
    assign io.rob_index      = pick.rob;
    assign io.occupancy      = count_q;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed vector table, corner-case sequences and
// random traffic checked against a queue-based reference model.
module tb_issue_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_queue_if bus ();
    issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(rst), .io(bus));

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] imm;
        logic        r1r;
        logic [5:0]  r1t;
        logic [31:0] r1v;
        logic        r2r;
        logic [5:0]  r2t;
        logic [31:0] r2v;
        logic [5:0]  dt;
        logic [5:0]  rob;
    } ment_t;

    typedef struct {
        logic        rst, dv;
        logic [3:0]  op;
        logic        r1r;
        logic [5:0]  r1t;
        logic [31:0] r1v;
        logic        r2r;
        logic [31:0] r2v;
        logic        wa;
        logic [5:0]  wt;
        logic [31:0] wv;
        logic        fu;
        logic        e_we;
        logic [3:0]  e_op;
        logic [31:0] e_rs1, e_rs2;
        logic [4:0]  e_occ;
        logic        e_drdy;
    } vec_t;

    ment_t mq[$];
    vec_t  tbl [9];
    int    checks = 0;
    int    errors = 0;
    bit    pred_we, pred_drdy;
    int    pred_k;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit src_ok(logic r, logic [5:0] t);
`ifdef ISSUE_WAKEUP_BYPASS_EN
        return r || (bus.wakeup_active && t == bus.wakeup_tag);
`else
        return r;
`endif
    endfunction

    function automatic logic [31:0] src_val(logic r, logic [31:0] v);
        return r ? v : bus.wakeup_value;
    endfunction

    // Predict outputs for the current inputs and compare at the falling edge.
    task automatic sample();
        @(negedge clk);
        pred_drdy = !rst && (mq.size() < DEPTH);
        pred_k = -1;
        for (int i = 0; i < mq.size(); i++)
            if (pred_k < 0 && src_ok(mq[i].r1r, mq[i].r1t) && src_ok(mq[i].r2r, mq[i].r2t))
                pred_k = i;
        pred_we = bus.fu_is_available && (pred_k >= 0) && !rst;
        chk("write_enable", bus.write_enable, pred_we);
        chk("occupancy", bus.occupancy, mq.size());
        chk("dispatch_ready", bus.dispatch_ready, pred_drdy);
        if (pred_we) begin
            chk("ALUControl", bus.ALUControl, mq[pred_k].op);
            chk("ALUSrc", bus.ALUSrc, mq[pred_k].src);
            chk("imm", bus.imm, mq[pred_k].imm);
            chk("rs1_value", bus.rs1_value, src_val(mq[pred_k].r1r, mq[pred_k].r1v));
            chk("rs2_value", bus.rs2_value, src_val(mq[pred_k].r2r, mq[pred_k].r2v));
            chk("tag_to_output", bus.tag_to_output, mq[pred_k].dt);
            chk("rob_index", bus.rob_index, mq[pred_k].rob);
        end
    endtask

    // Apply the cycle's effect to the model, then cross the rising edge.
    task automatic advance();
        ment_t e;
        if (rst) begin
            mq.delete();
        end else begin
            if (pred_we) mq.delete(pred_k);
            foreach (mq[i]) begin
                if (bus.wakeup_active && !mq[i].r1r && mq[i].r1t == bus.wakeup_tag) begin
                    mq[i].r1r = 1'b1; mq[i].r1v = bus.wakeup_value;
                end
                if (bus.wakeup_active && !mq[i].r2r && mq[i].r2t == bus.wakeup_tag) begin
                    mq[i].r2r = 1'b1; mq[i].r2v = bus.wakeup_value;
                end
            end
            if (bus.dispatch_valid && pred_drdy) begin
                e.op = bus.dispatch_ALUControl; e.src = bus.dispatch_ALUSrc; e.imm = bus.dispatch_imm;
                e.r1t = bus.dispatch_rs1_tag; e.r2t = bus.dispatch_rs2_tag;
                e.dt = bus.dispatch_tag_to_output; e.rob = bus.dispatch_rob_index;
                e.r1r = bus.dispatch_rs1_ready; e.r1v = bus.dispatch_rs1_value;
                e.r2r = bus.dispatch_rs2_ready || bus.dispatch_ALUSrc; e.r2v = bus.dispatch_rs2_value;
                if (!e.r1r && bus.wakeup_active && e.r1t == bus.wakeup_tag) begin
                    e.r1r = 1'b1; e.r1v = bus.wakeup_value;
                end
                if (!e.r2r && bus.wakeup_active && e.r2t == bus.wakeup_tag) begin
                    e.r2r = 1'b1; e.r2v = bus.wakeup_value;
                end
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(logic fu);
        bus.dispatch_valid = 1'b0; bus.wakeup_active = 1'b0; bus.fu_is_available = fu;
    endtask

    task automatic disp(logic [3:0] op, logic r1r, logic [5:0] r1t, logic [31:0] r1v,
                        logic r2r, logic [31:0] r2v, logic [5:0] rob);
        bus.dispatch_valid = 1'b1; bus.dispatch_ALUControl = op; bus.dispatch_ALUSrc = 1'b0;
        bus.dispatch_imm = $urandom; bus.dispatch_rs1_ready = r1r; bus.dispatch_rs1_tag = r1t;
        bus.dispatch_rs1_value = r1v; bus.dispatch_rs2_ready = r2r; bus.dispatch_rs2_tag = 6'd0;
        bus.dispatch_rs2_value = r2v; bus.dispatch_tag_to_output = rob + 6'd32;
        bus.dispatch_rob_index = rob;
    endtask

    initial begin
        tbl[0] = '{1,0,0,0,0,0,0,0,    0,0,0,0,      0,0,0,0,0,0};
        tbl[1] = '{0,1,2,1,0,5,1,7,    0,0,0,1,      0,0,0,0,0,1};
        tbl[2] = '{0,0,0,0,0,0,0,0,    0,0,0,1,      1,2,5,7,1,1};
        tbl[3] = '{0,1,3,0,12,0,1,1,   0,0,0,1,      0,0,0,0,0,1};
        tbl[4] = '{0,0,0,0,0,0,0,0,    1,12,'hF0,0,  0,0,0,0,1,1};
        tbl[5] = '{0,0,0,0,0,0,0,0,    0,0,0,1,      1,3,'hF0,1,1,1};
        tbl[6] = '{0,1,5,0,9,0,1,3,    1,9,42,1,     0,0,0,0,0,1};
        tbl[7] = '{0,0,0,0,0,0,0,0,    0,0,0,1,      1,5,42,3,1,1};
        tbl[8] = '{0,0,0,0,0,0,0,0,    0,0,0,1,      0,0,0,0,0,1};

        rst = 1'b1;
        idle(1'b0);
        disp(0, 0, 0, 0, 0, 0, 0);
        bus.dispatch_valid = 1'b0;
        bus.wakeup_tag = 0; bus.wakeup_value = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 9; r++) begin
            rst = tbl[r].rst;
            disp(tbl[r].op, tbl[r].r1r, tbl[r].r1t, tbl[r].r1v, tbl[r].r2r, tbl[r].r2v, 6'(r));
            bus.dispatch_valid = tbl[r].dv;
            bus.wakeup_active = tbl[r].wa; bus.wakeup_tag = tbl[r].wt; bus.wakeup_value = tbl[r].wv;
            bus.fu_is_available = tbl[r].fu;
            sample();
            chk($sformatf("row%0d_we", r), bus.write_enable, tbl[r].e_we);
            chk($sformatf("row%0d_occ", r), bus.occupancy, tbl[r].e_occ);
            chk($sformatf("row%0d_drdy", r), bus.dispatch_ready, tbl[r].e_drdy);
            if (tbl[r].e_we) begin
                chk($sformatf("row%0d_op", r), bus.ALUControl, tbl[r].e_op);
                chk($sformatf("row%0d_rs1", r), bus.rs1_value, tbl[r].e_rs1);
                chk($sformatf("row%0d_rs2", r), bus.rs2_value, tbl[r].e_rs2);
            end
            advance();
        end

        // Fill with waiting entries, then wake entry 3 only.
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'd1, 0, 6'(20 + i), 0, 1, 32'(i), 6'(i));
            bus.fu_is_available = 1'b1;
            sample(); advance();
        end
        disp(4'd1, 1, 0, 1, 1, 1, 6'd50);
        sample();
        chk("full_occ", bus.occupancy, 8);
        chk("full_drdy", bus.dispatch_ready, 0);
        chk("full_we", bus.write_enable, 0);
        advance();
        idle(1'b1);
        bus.wakeup_active = 1'b1; bus.wakeup_tag = 6'd23; bus.wakeup_value = 32'h1234;
        sample();
`ifdef ISSUE_WAKEUP_BYPASS_EN
        chk("wake3_we", bus.write_enable, 1);
        chk("wake3_rob", bus.rob_index, 3);
        chk("wake3_rs1", bus.rs1_value, 32'h1234);
        advance();
`else
        chk("wake3_we", bus.write_enable, 0);
        advance();
        idle(1'b1);
        sample();
        chk("wake3_we", bus.write_enable, 1);
        chk("wake3_rob", bus.rob_index, 3);
        chk("wake3_rs1", bus.rs1_value, 32'h1234);
        advance();
`endif
        idle(1'b0);
        sample();
        chk("after_full_drdy", bus.dispatch_ready, 1);
        chk("after_full_occ", bus.occupancy, 7);
        advance();
        rst = 1'b1; sample(); advance(); rst = 1'b0;

        // Entries 1 and 4 ready among waiting ones; FU stalls two cycles.
        for (int i = 0; i < 5; i++) begin
            disp(4'd6, (i == 1 || i == 4), 6'd30, 32'(100 + i), 1, 0, 6'(i));
            bus.fu_is_available = 1'b0;
            sample(); advance();
        end
        idle(1'b0);
        for (int i = 0; i < 2; i++) begin
            sample(); chk("stall_we", bus.write_enable, 0); advance();
        end
        idle(1'b1);
        sample(); chk("prio_first_we", bus.write_enable, 1); chk("prio_first_rob", bus.rob_index, 1); advance();
        sample(); chk("prio_second_we", bus.write_enable, 1); chk("prio_second_rob", bus.rob_index, 4); advance();

        // Wake the remaining three, then reset with the FU available.
        idle(1'b0);
        bus.wakeup_active = 1'b1; bus.wakeup_tag = 6'd30; bus.wakeup_value = 32'd77;
        sample(); advance();
        idle(1'b1);
        rst = 1'b1;
        sample(); chk("reset_we", bus.write_enable, 0); chk("reset_occ_before", bus.occupancy, 3); advance();
        rst = 1'b0;
        sample(); chk("post_reset_occ", bus.occupancy, 0); chk("post_reset_we", bus.write_enable, 0); advance();

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            disp(4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)));
            bus.dispatch_rs2_tag = 6'($urandom_range(0, 7));
            bus.dispatch_ALUSrc = 1'($urandom_range(0, 3) == 0);
            bus.dispatch_valid = ($urandom_range(0, 9) < 6);
            bus.wakeup_active = ($urandom_range(0, 1) == 1);
            bus.wakeup_tag = 6'($urandom_range(0, 7));
            bus.wakeup_value = $urandom;
            bus.fu_is_available = ($urandom_range(0, 3) != 0);
            sample(); advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
